// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Accept -> operands on ALU next cycle -> result held on resp_* until taken; 1 op / 3 cycles peak.
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_carry,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rid_q, rid_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             rv_q, rv_d;
  logic             gnt0, gnt1;

  // A lone requester always wins; on contention the pointer decides.
  assign gnt0 = req0_valid & (~req1_valid | ~ptr_q);
  assign gnt1 = req1_valid & (~req0_valid | ptr_q);

  assign req0_ready = (state_q == IDLE) & gnt0 & ~reset;
  assign req1_ready = (state_q == IDLE) & gnt1 & ~reset;

  assign alu_in_a   = a_q;
  assign alu_in_b   = b_q;
  assign alu_opcode = op_q;
  assign resp_valid = rv_q;
  assign resp_id    = rid_q;
  assign resp_data  = data_q;
  assign resp_zero  = zero_q;
  assign resp_carry = carry_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    data_d  = data_q;
    rid_d   = rid_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    rv_d    = rv_q;
    case (state_q)
      IDLE: begin
        if (req0_valid && req0_ready) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = req0_op;
          id_d    = 1'b0;
          ptr_d   = 1'b1;
          state_d = EXEC;
        end else if (req1_valid && req1_ready) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = req1_op;
          id_d    = 1'b1;
          ptr_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_out;
        zero_d  = alu_zero;
        carry_d = alu_carry;
        rid_d   = id_q;
        rv_d    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        // Returning to IDLE first means no accept can coincide with the response handshake.
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      rid_q   <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rid_q   <= rid_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      rv_q    <= rv_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an 8-bit adder standing in for the ALU.
module tb_alu_arbiter;
  localparam int WIDTH = 8;
  localparam int OPW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic             resp_valid, resp_ready, resp_id, resp_zero, resp_carry;
  logic [WIDTH-1:0] resp_data, alu_in_a, alu_in_b, alu_out;
  logic [OPW-1:0]   alu_opcode;
  logic             alu_zero, alu_carry, busy;
  logic [WIDTH:0]   sum;

  assign sum       = {1'b0, alu_in_a} + {1'b0, alu_in_b};
  assign alu_out   = sum[WIDTH-1:0];
  assign alu_carry = sum[WIDTH];
  assign alu_zero  = (alu_out == '0);

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_carry(resp_carry),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gid;
    reset = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_op = 4'h3;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 4'h0;

    // Reset state, with req0_valid already high to show ready is forced low
    nxt(); #1;
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_alu", {alu_in_a, alu_in_b, alu_opcode}, 0);
    chk("rst_resp", {resp_data, resp_id, resp_zero, resp_carry}, 0);

    // Single request: 0x12 + 0x34 = 0x46
    nxt(); reset = 1'b0; resp_ready = 1'b1; #1;
    chk("s_rdy0", req0_ready, 1);
    chk("s_rdy1", req1_ready, 0);
    chk("s_busy0", busy, 0);
    nxt(); req0_valid = 1'b0; #1;
    chk("s_alu_a", alu_in_a, 8'h12);
    chk("s_alu_b", alu_in_b, 8'h34);
    chk("s_alu_op", alu_opcode, 4'h3);
    chk("s_busy1", busy, 1);
    chk("s_rv1", resp_valid, 0);
    nxt(); #1;
    chk("s_rv2", resp_valid, 1);
    chk("s_data", resp_data, 8'h46);
    chk("s_zc", {resp_zero, resp_carry}, 2'b00);
    chk("s_id", resp_id, 0);
    chk("s_busy2", busy, 1);
    nxt(); #1;
    chk("s_idle", busy, 0);
    chk("s_rv3", resp_valid, 0);

    // Flags: 0xFF + 0x01 wraps to zero with carry
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01; req1_op = 4'h1; #1;
    chk("f_rdy1", req1_ready, 1);
    nxt(); req1_valid = 1'b0; #1;
    nxt(); #1;
    chk("f_data", resp_data, 8'h00);
    chk("f_zero", resp_zero, 1);
    chk("f_carry", resp_carry, 1);
    chk("f_id", resp_id, 1);
    nxt(); reset = 1'b1;

    // Contention from reset: 0x10+0x20=0x30, 0x80+0x90=0x110
    nxt(); reset = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 4'h1;
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h90; req1_op = 4'h2;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) nxt();
      #1;
      gid = (c / 3) % 2;
      chk("c_excl", req0_ready & req1_ready, 0);
      chk("c_rdy0", req0_ready, (c % 3 == 0) && (gid == 0));
      chk("c_rdy1", req1_ready, (c % 3 == 0) && (gid == 1));
      if (c % 3 == 2) begin
        chk("c_id", resp_id, gid);
        chk("c_data", resp_data, (gid == 0) ? 8'h30 : 8'h10);
        chk("c_carry", resp_carry, gid);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: pointer is back at 0 after the last req1 grant
    nxt(); resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h07; req0_op = 4'h4;
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02; req1_op = 4'h6; #1;
    chk("b_rdy0", req0_ready, 1);
    nxt(); req0_valid = 1'b0; #1;
    chk("b_exec_rdy1", req1_ready, 0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      if (i != 0) nxt();
      #1;
      chk("b_rv", resp_valid, 1);
      chk("b_data", resp_data, 8'h0C);
      chk("b_id", resp_id, 0);
      chk("b_zc", {resp_zero, resp_carry}, 2'b00);
      chk("b_rdy", {req0_ready, req1_ready}, 2'b00);
    end
    nxt(); resp_ready = 1'b1; #1;
    chk("b_rv_hs", resp_valid, 1);
    chk("b_rdy1_hs", req1_ready, 0);
    nxt(); #1;
    chk("b_resume", req1_ready, 1);
    chk("b_rv_low", resp_valid, 0);
    nxt(); req1_valid = 1'b0; #1;
    nxt(); #1;
    chk("b_data2", resp_data, 8'h03);
    chk("b_id2", resp_id, 1);

    // Reset while in EXEC
    nxt(); req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h44; req0_op = 4'h5; #1;
    chk("m_rdy0", req0_ready, 1);
    nxt(); req0_valid = 1'b0; reset = 1'b1; #1;
    chk("m_exec", busy, 1);
    nxt(); #1;
    chk("m_busy", busy, 0);
    chk("m_rv", resp_valid, 0);
    chk("m_alu", {alu_in_a, alu_in_b, alu_opcode}, 0);
    chk("m_resp", {resp_data, resp_id, resp_zero, resp_carry}, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("m_norsp", resp_valid, 0);
    end
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01;
    req1_valid = 1'b1; req1_a = 8'h02; req1_b = 8'h02; #1;
    chk("m_ptr0", req0_ready, 1);
    chk("m_ptr1", req1_ready, 0);

    // Withdrawn request during RESP
    nxt(); req0_valid = 1'b0;
    nxt(); nxt(); #1;
    chk("w_rdy1", req1_ready, 1);
    resp_ready = 1'b0;
    nxt(); req1_valid = 1'b0;
    nxt(); req0_valid = 1'b1; #1;
    chk("w_pulse", req0_ready, 0);
    nxt(); req0_valid = 1'b0; #1;
    chk("w_id", resp_id, 1);
    chk("w_data", resp_data, 8'h04);
    resp_ready = 1'b1;
    nxt(); #1;
    chk("w_busy", busy, 0);
    chk("w_rdy0", req0_ready, 0);
    chk("w_alu_a", alu_in_a, 8'h02);
    nxt(); #1;
    chk("w_busy2", busy, 0);
    chk("w_rv", resp_valid, 0);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("w_ptr0", req0_ready, 1);
    chk("w_ptr1", req1_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (in_a, in_b, opcode in; alu_out, alu_zero, alu_carry out) between two requesters.
- Round-robin arbitration with valid/ready handshakes on each request port.
- Registers the granted operands and opcode, drives them onto the ALU for one cycle, and captures the result and flags.
- Returns the result on a single shared response channel tagged with the requester id.
- Sits between the datapath control units and the ALU instance.

Parameters:
- WIDTH, 8, operand and result width; must match the ALU data width.
- OPW, 4, opcode width; must match the ALU opcode width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_op  input  OPW  requester 0 ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions, widths and meanings as the req0 signals, for requester 1.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes the result.
- resp_id  output  1  index of the requester that owns the result.
- resp_data  output  WIDTH  captured alu_out.
- resp_zero  output  1  captured alu_zero.
- resp_carry  output  1  captured alu_carry.
- alu_in_a  output  WIDTH  to ALU in_a; registered.
- alu_in_b  output  WIDTH  to ALU in_b; registered.
- alu_opcode  output  OPW  to ALU opcode; registered.
- alu_out  input  WIDTH  from ALU.
- alu_zero  input  1  from ALU.
- alu_carry  input  1  from ALU.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (synchronous, active-high):
  - state=IDLE, priority pointer ptr=0 (requester 0 favoured).
  - alu_in_a, alu_in_b, alu_opcode, resp_data, resp_id, resp_zero, resp_carry all 0.
  - resp_valid=0, busy=0.
  - req0_ready and req1_ready forced 0 while reset is high.
- An in-flight operation is discarded on reset: no response is produced and ptr returns to 0.
- IDLE, grant computation (combinational from the valids and ptr):
  - Only one valid: grant it.
  - Both valid: grant requester ptr.
  - reqN_ready = (state==IDLE) & grant_N & ~reset. At most one ready is high per cycle.
  - Ready may depend on valid; valid must not depend on ready.
- IDLE, on handshake (reqN_valid & reqN_ready):
  - Latch reqN_a, reqN_b, reqN_op into alu_in_a, alu_in_b, alu_opcode.
  - Latch N into the id register.
  - Set ptr = ~N.
  - Go to EXEC.
- IDLE with no valid: stay in IDLE; ptr unchanged.
- EXEC: lasts exactly one cycle. At its end:
  - resp_data<=alu_out, resp_zero<=alu_zero, resp_carry<=alu_carry, resp_id<=id.
  - resp_valid<=1; go to RESP.
- RESP:
  - resp_* outputs held stable while resp_valid=1 and resp_ready=0 (unbounded backpressure).
  - On resp_valid & resp_ready: resp_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Timing:
  - Accept in cycle N; ALU operands valid in N+1; resp_valid high from N+2.
  - With resp_ready held high, the next accept happens at N+3, so peak throughput is 1 op per 3 cycles.
- ALU outputs (alu_in_a, alu_in_b, alu_opcode) keep the last issued values outside EXEC; they change only on an accept or on reset.
- Requester obligations: hold valid, a, b and op stable until ready. Dropping valid before ready is legal; that request is simply never issued.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,… starting from ptr.
- Width rule: no arithmetic inside the block. Data and flags pass through unmodified at WIDTH/OPW.

Test Plan:
- Bench ALU model for all scenarios: alu_out = (a+b) mod 256, alu_carry = bit 8 of a+b, alu_zero = (alu_out==0).
- Single request: after reset, req0 a=0x12 b=0x34 op=0x3, resp_ready=1 -> req0_ready in cycle 0; alu_in_a=0x12, alu_in_b=0x34, alu_opcode=0x3 in cycle 1; resp_valid=1 in cycle 2 with resp_data=0x46, zero=0, carry=0, id=0; busy high in cycles 1–2.
- Flags: req1 a=0xFF b=0x01 -> resp_data=0x00, resp_zero=1, resp_carry=1, resp_id=1.
- Contention: both valid continuously from reset, resp_ready=1 -> grant order 0,1,0,1; one accept every 3 cycles; req0_ready and req1_ready never high together.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid rises -> resp_data, resp_id, resp_zero, resp_carry stable; both readys stay 0; accept resumes the cycle after the resp_ready handshake.
- Reset mid-operation: assert reset during EXEC -> next cycle state=IDLE, resp_valid=0, all registered outputs 0, ptr=0; no response ever appears for the aborted op.
- Idle/withdraw: req0_valid pulses for 1 cycle while state=RESP -> never issued; ptr unchanged; busy returns to 0.
